// File: rtl/alu_share_arb_if.sv
// Bundle of requester, response and shared-ALU signals for alu_share_arb.
// master: the environment (requesters, response sinks, ALU); slave: the arbiter.
interface alu_share_arb_if #(
   parameter int unsigned XLEN = 32
);
   // requester 0 / 1 operation channels
   logic            req0_valid;
   logic            req0_ready;
   logic [3:0]      req0_ctrl;
   logic [XLEN-1:0] req0_a;
   logic [XLEN-1:0] req0_b;
   logic            req1_valid;
   logic            req1_ready;
   logic [3:0]      req1_ctrl;
   logic [XLEN-1:0] req1_a;
   logic [XLEN-1:0] req1_b;

   // shared combinational ALU
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] alu_result;

   // response channels
   logic            rsp0_valid;
   logic            rsp0_ready;
   logic [XLEN-1:0] rsp0_data;
   logic            rsp1_valid;
   logic            rsp1_ready;
   logic [XLEN-1:0] rsp1_data;

   modport master (
      output req0_valid, req0_ctrl, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_ctrl, req1_a, req1_b,
      input  req1_ready,
      input  alu_a, alu_b, alu_ctrl,
      output alu_result,
      input  rsp0_valid, rsp0_data,
      output rsp0_ready,
      input  rsp1_valid, rsp1_data,
      output rsp1_ready
   );

   modport slave (
      input  req0_valid, req0_ctrl, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_ctrl, req1_a, req1_b,
      output req1_ready,
      output alu_a, alu_b, alu_ctrl,
      input  alu_result,
      output rsp0_valid, rsp0_data,
      input  rsp0_ready,
      output rsp1_valid, rsp1_data,
      input  rsp1_ready
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. One operation in flight: IDLE (grant) -> EXEC (1 cycle) -> RESP.
module alu_share_arb #(
   parameter int unsigned XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_share_arb_if.slave       bus
);

   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_OR   = 4'b0001;
   localparam logic [3:0] CTRL_ADD  = 4'b0010;
   localparam logic [3:0] CTRL_SUB  = 4'b0110;
   localparam logic [3:0] CTRL_SLTU = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // arbitration
   logic            rr;          // requester favoured on contention (0 = req0)
   logic            gnt_valid;
   logic            gnt_id;
   logic            owner;       // requester owning the in-flight operation

   // selected request payload
   logic [3:0]      sel_ctrl;
   logic [XLEN-1:0] sel_a;
   logic [XLEN-1:0] sel_b;

   // registered outputs
   logic [XLEN-1:0] alu_a_q;
   logic [XLEN-1:0] alu_b_q;
   logic [3:0]      alu_ctrl_q;
   logic            rsp0_valid_q;
   logic            rsp1_valid_q;
   logic [XLEN-1:0] rsp0_data_q;
   logic [XLEN-1:0] rsp1_data_q;

   logic            rsp_ack;

   // Unknown control codes fall back to ADD.
   function automatic logic [3:0] sanitise(input logic [3:0] c);
      case (c)
         CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLTU: sanitise = c;
         default:                                         sanitise = CTRL_ADD;
      endcase
   endfunction

   // Grant selection: single requester wins outright, contention goes to rr.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (state == IDLE && !rst) begin
         case ({bus.req1_valid, bus.req0_valid})
            2'b01: begin
               gnt_valid = 1'b1;
               gnt_id    = 1'b0;
            end
            2'b10: begin
               gnt_valid = 1'b1;
               gnt_id    = 1'b1;
            end
            2'b11: begin
               gnt_valid = 1'b1;
               gnt_id    = rr;
            end
            default: begin
               gnt_valid = 1'b0;
               gnt_id    = 1'b0;
            end
         endcase
      end
   end

   // Payload mux for the granted requester.
   always_comb begin
      sel_ctrl = bus.req0_ctrl;
      sel_a    = bus.req0_a;
      sel_b    = bus.req0_b;
      if (gnt_id) begin
         sel_ctrl = bus.req1_ctrl;
         sel_a    = bus.req1_a;
         sel_b    = bus.req1_b;
      end
   end

   // Response handshake for the current owner.
   assign rsp_ack = owner ? (rsp1_valid_q & bus.rsp1_ready)
                          : (rsp0_valid_q & bus.rsp0_ready);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_valid) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, rr pointer, result capture and response valids.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr           <= 1'b0;
         owner        <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= CTRL_ADD;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         // handshake: the ALU operand registers double as the operation latch
         if (gnt_valid) begin
            alu_a_q    <= sel_a;
            alu_b_q    <= sel_b;
            alu_ctrl_q <= sanitise(sel_ctrl);
            owner      <= gnt_id;
            rr         <= ~gnt_id;
         end
         // single execute cycle: capture result, park the ALU inputs
         if (state == EXEC) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= CTRL_ADD;
            if (owner) begin
               rsp1_data_q  <= bus.alu_result;
               rsp1_valid_q <= 1'b1;
            end else begin
               rsp0_data_q  <= bus.alu_result;
               rsp0_valid_q <= 1'b1;
            end
         end
         // response consumed
         if (state == RESP && rsp_ack) begin
            if (owner) rsp1_valid_q <= 1'b0;
            else       rsp0_valid_q <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = gnt_valid & ~gnt_id;
   assign bus.req1_ready = gnt_valid &  gnt_id;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_ctrl   = alu_ctrl_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp0_data  = rsp0_data_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: the bench plays both requesters and the
// ALU; expected results are queued at each grant and checked on response.
module tb_alu_share_arb;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_share_arb_if #(.XLEN(XLEN)) bus ();

   alu_share_arb #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference ALU; unknown codes give a poison value.
   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      case (c)
         4'b0000: alu_f = a & b;
         4'b0001: alu_f = a | b;
         4'b0010: alu_f = a + b;
         4'b0110: alu_f = a - b;
         4'b0111: alu_f = {31'd0, a < b};
         default: alu_f = 32'hDEAD_BEEF;
      endcase
   endfunction

   assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          hs_cyc = 0;
   logic [31:0] last_data [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic drive0(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.req0_valid = 1'b1;
      bus.req0_ctrl  = c;
      bus.req0_a     = a;
      bus.req0_b     = b;
   endtask

   task automatic drive1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.req1_valid = 1'b1;
      bus.req1_ctrl  = c;
      bus.req1_a     = a;
      bus.req1_b     = b;
   endtask

   // Hold reset two cycles, then check every reset value.
   task automatic reset_dut();
      rst            = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
      chk("rst_rsp1_data", bus.rsp1_data, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_b", bus.alu_b, 32'd0);
      chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      rst          = 1'b0;
      last_data[0] = '0;
      last_data[1] = '0;
   endtask

   // Wait (bounded) for a ready in IDLE, check the winner, queue its result.
   task automatic grant_step(input int exp_id, input logic [31:0] exp_data, input bit do_push);
      int got = -1;
      #1;
      for (int k = 0; k < 10 && got < 0; k++) begin
         if (bus.req0_ready)      got = 0;
         else if (bus.req1_ready) got = 1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk("grant_id", 32'(got), 32'(exp_id));
      chk("ready_onehot", 32'({bus.req1_ready, bus.req0_ready}), (exp_id == 1) ? 32'd2 : 32'd1);
      hs_cyc = cyc;
      if (do_push && got >= 0) sb.push_back('{exp_id, exp_data});
   endtask

   // Next cycle is EXEC: check ALU drive and that nothing is ready.
   task automatic exec_step(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      chk("exec_alu_ctrl", 32'(bus.alu_ctrl), 32'(c));
      chk("exec_alu_a", bus.alu_a, a);
      chk("exec_alu_b", bus.alu_b, b);
      chk("exec_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
   endtask

   // Wait (bounded) for the response, compare with the queue head, hold the
   // response for 'delay' cycles, then consume it.
   task automatic resp_step(input int delay);
      int   waited = 0;
      exp_t e;
      logic own_v;
      logic oth_v;
      logic [31:0] own_d;
      logic [31:0] oth_d;
      while (!(bus.rsp0_valid || bus.rsp1_valid) && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      chk("rsp_latency", 32'(cyc - hs_cyc), 32'd2);
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      for (int k = 0; k <= delay; k++) begin
         if (k > 0) @(negedge clk);
         own_v = (e.id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
         oth_v = (e.id == 1) ? bus.rsp0_valid : bus.rsp1_valid;
         own_d = (e.id == 1) ? bus.rsp1_data  : bus.rsp0_data;
         oth_d = (e.id == 1) ? bus.rsp0_data  : bus.rsp1_data;
         chk("rsp_own_valid", 32'(own_v), 32'd1);
         chk("rsp_other_valid", 32'(oth_v), 32'd0);
         chk("rsp_data", own_d, e.data);
         chk("rsp_other_data", oth_d, last_data[1 - e.id]);
      end
      if (e.id == 1) bus.rsp1_ready = 1'b1;
      else           bus.rsp0_ready = 1'b1;
      @(negedge clk);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      own_v = (e.id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
      chk("rsp_cleared", 32'(own_v), 32'd0);
      chk("idle_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      chk("idle_alu_a", bus.alu_a, 32'd0);
      last_data[e.id] = e.data;
   endtask

   logic [3:0]  c0 [4];
   logic [31:0] a0 [4];
   logic [31:0] b0 [4];
   logic [31:0] e0 [4];
   logic [3:0]  c1 [4];
   logic [31:0] a1 [4];
   logic [31:0] b1 [4];
   logic [31:0] e1 [4];

   initial begin
      int i0;
      int i1;
      int eid;
      bus.req0_valid = 1'b0;
      bus.req0_ctrl  = 4'd0;
      bus.req0_a     = '0;
      bus.req0_b     = '0;
      bus.req1_valid = 1'b0;
      bus.req1_ctrl  = 4'd0;
      bus.req1_a     = '0;
      bus.req1_b     = '0;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;

      c0 = '{4'h0, 4'h1, 4'h7, 4'h2};
      a0 = '{32'h0000_00F0, 32'h0000_00F0, 32'd1, 32'd100};
      b0 = '{32'h0000_003C, 32'h0000_000F, 32'd7, 32'd23};
      e0 = '{32'h0000_0030, 32'h0000_00FF, 32'd1, 32'd123};
      c1 = '{4'h2, 4'h6, 4'h0, 4'h1};
      a1 = '{32'd10, 32'd9, 32'h0000_FF00, 32'h8000_0000};
      b1 = '{32'd20, 32'd10, 32'h0000_0FF0, 32'd1};
      e1 = '{32'd30, 32'hFFFF_FFFF, 32'h0000_0F00, 32'h8000_0001};

      reset_dut();

      // req0 ADD 5+7
      drive0(4'h2, 32'd5, 32'd7);
      grant_step(0, 32'd12, 1'b1);
      exec_step(4'h2, 32'd5, 32'd7);
      bus.req0_valid = 1'b0;
      resp_step(0);

      // req1 SUB 3-5, response held 4 cycles
      drive1(4'h6, 32'd3, 32'd5);
      grant_step(1, 32'hFFFF_FFFE, 1'b1);
      exec_step(4'h6, 32'd3, 32'd5);
      bus.req1_valid = 1'b0;
      resp_step(4);

      // both continuously valid from reset: grants alternate 0,1,0,1...
      reset_dut();
      i0 = 0;
      i1 = 0;
      drive0(c0[0], a0[0], b0[0]);
      drive1(c1[0], a1[0], b1[0]);
      for (int i = 0; i < 8; i++) begin
         eid = i % 2;
         if (eid == 0) begin
            grant_step(0, e0[i0], 1'b1);
            exec_step(c0[i0], a0[i0], b0[i0]);
            i0++;
            if (i0 < 4) drive0(c0[i0], a0[i0], b0[i0]);
            else        bus.req0_valid = 1'b0;
         end else begin
            grant_step(1, e1[i1], 1'b1);
            exec_step(c1[i1], a1[i1], b1[i1]);
            i1++;
            if (i1 < 4) drive1(c1[i1], a1[i1], b1[i1]);
            else        bus.req1_valid = 1'b0;
         end
         resp_step(0);
      end

      // illegal ctrl is executed as ADD
      drive0(4'hF, 32'd2, 32'd3);
      grant_step(0, 32'd5, 1'b1);
      exec_step(4'h2, 32'd2, 32'd3);
      bus.req0_valid = 1'b0;
      resp_step(1);

      // reset during EXEC of a req1 op: dropped, then req0 wins contention
      drive1(4'h2, 32'd1, 32'd1);
      grant_step(1, 32'd0, 1'b0);
      exec_step(4'h2, 32'd1, 32'd1);
      rst = 1'b1;
      drive0(4'h2, 32'd40, 32'd2);
      @(negedge clk);
      rst          = 1'b0;
      last_data[0] = '0;
      last_data[1] = '0;
      chk("rst_exec_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("rst_exec_rsp1_data", bus.rsp1_data, 32'd0);
      grant_step(0, 32'd42, 1'b1);
      exec_step(4'h2, 32'd40, 32'd2);
      bus.req0_valid = 1'b0;
      resp_step(0);
      grant_step(1, 32'd2, 1'b1);
      exec_step(4'h2, 32'd1, 32'd1);
      bus.req1_valid = 1'b0;
      resp_step(0);

      // reset during RESP of a req0 op (rr points at req1): response dropped,
      // rr back to req0
      drive0(4'h2, 32'd1, 32'd2);
      grant_step(0, 32'd0, 1'b0);
      exec_step(4'h2, 32'd1, 32'd2);
      @(negedge clk);
      chk("pre_rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      rst = 1'b1;
      drive0(4'h2, 32'd7, 32'd8);
      drive1(4'h1, 32'h10, 32'h01);
      @(negedge clk);
      rst          = 1'b0;
      last_data[0] = '0;
      last_data[1] = '0;
      chk("rst_resp_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("rst_resp_rsp0_data", bus.rsp0_data, 32'd0);
      grant_step(0, 32'd15, 1'b1);
      exec_step(4'h2, 32'd7, 32'd8);
      bus.req0_valid = 1'b0;
      resp_step(0);
      grant_step(1, 32'h11, 1'b1);
      exec_step(4'h1, 32'h10, 32'h01);
      bus.req1_valid = 1'b0;
      resp_step(0);

      // req0 waits behind req1 and changes operands; its own handshake counts
      drive0(4'h2, 32'd3, 32'd4);
      grant_step(0, 32'd7, 1'b1);
      exec_step(4'h2, 32'd3, 32'd4);
      drive0(4'h2, 32'd1, 32'd1);
      drive1(4'h0, 32'hFF, 32'h0F);
      resp_step(0);
      grant_step(1, 32'h0F, 1'b1);
      exec_step(4'h0, 32'hFF, 32'h0F);
      bus.req1_valid = 1'b0;
      drive0(4'h2, 32'd100, 32'd23);
      resp_step(2);
      grant_step(0, 32'd123, 1'b1);
      exec_step(4'h2, 32'd100, 32'd23);
      bus.req0_valid = 1'b0;
      resp_step(0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
